// File: rtl/photonic_packet_tx.sv
// Buffered packet transmitter for one photonic link port: packets queue in a FIFO
// and leave as NUM_FLITS LSB-first flits of LINK_WIDTH bits, paced by tx_grant.
module photonic_packet_tx #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LINK_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ID_WIDTH-1:0]               dest_id,
  input  logic [DATA_WIDTH-1:0]             data,
  input  logic [ID_WIDTH-1:0]               src_id,
  input  logic                              tx_enable,
  input  logic                              tx_grant,
  output logic                              tx_valid,
  output logic [LINK_WIDTH-1:0]             tx_out,
  output logic                              tx_sof,
  output logic                              tx_eof,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int PKT_WIDTH = 2*ID_WIDTH + DATA_WIDTH;
  localparam int NUM_FLITS = (PKT_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
  localparam int SH_W      = NUM_FLITS * LINK_WIDTH;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH+1);
  localparam int FC_W      = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [PKT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic [FC_W-1:0]      flit_cnt_q, flit_cnt_d;
  logic                 sof_q, sof_d, eof_q, eof_d;
  logic                 push, pop, consume, last_flit, fifo_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_count = count_q;

  assign push      = in_valid && in_ready;
  assign consume   = (state_q == SEND) && tx_grant;
  assign last_flit = (flit_cnt_q == FC_W'(NUM_FLITS-1));
  // A new packet loads either from idle or on the edge retiring the eof flit (no bubble).
  assign pop       = tx_enable && !fifo_empty && ((state_q == IDLE) || (consume && last_flit));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    flit_cnt_d = flit_cnt_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      state_d    = SEND;
      shift_d    = SH_W'(mem_q[rd_ptr_q]);
      flit_cnt_d = '0;
      sof_d      = 1'b1;
      eof_d      = (NUM_FLITS == 1);
    end else if (consume) begin
      if (last_flit) begin
        // Shift register returns to zero so an idle lane drives all-zero.
        state_d    = IDLE;
        shift_d    = '0;
        flit_cnt_d = '0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
      end else begin
        shift_d    = shift_q >> LINK_WIDTH;
        flit_cnt_d = flit_cnt_q + FC_W'(1);
        sof_d      = 1'b0;
        eof_d      = (flit_cnt_d == FC_W'(NUM_FLITS-1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      flit_cnt_q <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      flit_cnt_q <= flit_cnt_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {src_id, data, dest_id};
  end

  assign tx_valid = (state_q == SEND);
  assign tx_out   = shift_q[LINK_WIDTH-1:0];
  assign tx_sof   = sof_q;
  assign tx_eof   = eof_q;

endmodule
